// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the instruction fetch stage.
// Ports: CLK/resetl (clock, async active-low reset); startPC (boot address);
//   stall/halt (downstream backpressure, permanent stop); br_valid, br_pc,
//   br_imm, Branch, ALUZero, Uncondbranch (resolved branch from execute);
//   imem_ack/imem_req/imem_addr (instruction memory handshake);
//   CurrentPC (registered PC); instr_valid, redirect, fault (status outputs).
// Optional feature: define PC_ALIGN_CHECK_EN to trap taken branches whose
//   target is not 4-byte aligned in a sticky FAULT state.
module pc_sequencer (
  input  logic        CLK,
  input  logic        resetl,
  input  logic [63:0] startPC,
  input  logic        stall,
  input  logic        halt,
  input  logic        br_valid,
  input  logic [63:0] br_pc,
  input  logic [63:0] br_imm,
  input  logic        Branch,
  input  logic        ALUZero,
  input  logic        Uncondbranch,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  output logic [63:0] CurrentPC,
  output logic        instr_valid,
  output logic        redirect,
  output logic        fault
);

`ifdef PC_ALIGN_CHECK_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    STALL  = 3'd2,
    HALTED = 3'd3,
    FAULT  = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STALL  = 2'd2,
    HALTED = 2'd3
  } state_t;
`endif

  state_t      state, state_nxt;
  logic [63:0] pc, pc_nxt;
  logic        taken;
  logic [63:0] target;

  assign taken  = br_valid && (Uncondbranch || (Branch && ALUZero));
  // Word offset scaled to bytes; the top two immediate bits fall off, which
  // is the intended modulo-2^64 behaviour.
  assign target = br_pc + {br_imm[61:0], 2'b00};

  assign CurrentPC = pc;
  assign imem_addr = pc;

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state <= IDLE;
      pc    <= 64'd0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    redirect    = 1'b0;
    fault       = 1'b0;
    case (state)
      IDLE: begin
        pc_nxt    = startPC;
        state_nxt = FETCH;
      end
      FETCH, STALL: begin
        imem_req = (state == FETCH);
        if (halt) begin
          // halt outranks a same-cycle branch: PC is frozen where it is.
          state_nxt = HALTED;
        end else if (taken) begin
          // Any same-cycle ack is dropped; the fetch restarts at target.
          redirect  = 1'b1;
          pc_nxt    = target;
          state_nxt = FETCH;
`ifdef PC_ALIGN_CHECK_EN
          if (target[1:0] != 2'b00) state_nxt = FAULT;
`endif
        end else if (state == FETCH) begin
          if (imem_ack) begin
            if (stall) begin
              // Word is not consumed; it will be re-fetched after the stall.
              state_nxt = STALL;
            end else begin
              instr_valid = 1'b1;
              pc_nxt      = pc + 64'd4;
            end
          end
        end else if (!stall) begin
          state_nxt = FETCH;
        end
      end
      HALTED: begin
        state_nxt = HALTED;
      end
`ifdef PC_ALIGN_CHECK_EN
      FAULT: begin
        fault     = 1'b1;
        state_nxt = FAULT;
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have port CLK, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port resetl, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port startPC, input, 64, boot address, loaded on first edge after reset release.
REQ-004 SHALL have port stall, input, 1, downstream cannot accept an instruction this cycle.
REQ-005 SHALL have port halt, input, 1, stop fetching permanently until reset.
REQ-006 SHALL have ports br_valid (1), br_pc (64), br_imm (64), Branch (1), ALUZero (1), Uncondbranch (1), all inputs; together they describe a resolved branch from execute.
REQ-007 SHALL have port imem_ack, input, 1, instruction memory returns the word for imem_addr this cycle.
REQ-008 SHALL have port imem_req, output, 1, fetch request.
REQ-009 SHALL have port imem_addr, output, 64, always equal to CurrentPC.
REQ-010 SHALL have port CurrentPC, output, 64, registered PC.
REQ-011 SHALL have ports instr_valid (1), redirect (1) and fault (1), all outputs.

Function
REQ-012 SHALL implement states IDLE, FETCH, STALL, HALTED, plus FAULT when REQ-028 applies.
REQ-013 IDLE: imem_req=0; next edge loads PC<=startPC and goes to FETCH.
REQ-014 FETCH: imem_req=1; the request is held until acknowledged.
REQ-015 FETCH with imem_ack=1 and stall=0: instr_valid=1 combinationally; next edge PC<=PC+4 and state stays FETCH.
REQ-016 FETCH with imem_ack=1 and stall=1: instr_valid=0; PC holds; next edge goes to STALL.
REQ-017 FETCH with imem_ack=0: PC holds; state stays FETCH.
REQ-018 STALL: imem_req=0; instr_valid=0; when stall=0, next edge goes to FETCH and the same PC is re-fetched.
REQ-019 A branch is taken when br_valid=1 AND (Uncondbranch=1 OR (Branch=1 AND ALUZero=1)).
REQ-020 Taken target SHALL be br_pc + (br_imm << 2), computed modulo 2^64; wrap-around is silently allowed.
REQ-021 Taken branch in FETCH or STALL: redirect=1 combinationally; instr_valid is forced to 0 and any same-cycle ack is discarded; next edge PC<=target and state goes to FETCH.
REQ-022 A not-taken br_valid, or a branch in IDLE/HALTED/FAULT, SHALL have no effect.
REQ-023 Priority, highest first: reset, halt, taken branch, ack/stall.
REQ-024 halt=1 in FETCH or STALL: instr_valid=0; next edge goes to HALTED with PC held; HALTED has imem_req=0 and exits only via reset.
REQ-025 Outputs SHALL be glitch-free functions of state and current inputs only; there are no combinational paths other than those given in REQ-015 and REQ-021.

Reset
REQ-026 While resetl=0, asynchronously: state=IDLE, PC=0, imem_req=0, instr_valid=0, redirect=0, fault=0.
REQ-027 Reset asserted mid-fetch SHALL abandon the request immediately, with no PC update.

Configuration
REQ-028 With macro PC_ALIGN_CHECK_EN defined, a taken branch whose target[1:0]!=0 SHALL go to FAULT on the next edge, capturing PC<=target; FAULT drives fault=1 and imem_req=0 and exits only via reset.
REQ-029 Without PC_ALIGN_CHECK_EN, target[1:0] is not checked, the FAULT state is absent and fault is tied to 0.

Verification
REQ-030 Reset release, startPC=0x1000, imem_ack=1, stall=0 -> IDLE for 1 cycle, then imem_addr sequence 0x1000, 0x1004, 0x1008 with instr_valid=1 on each.
REQ-031 PC=0x2000 with ack=1 and stall=1 for 2 cycles, then stall=0 -> STALL entered, imem_req=0 during the stall, then 0x2000 re-fetched and PC advances to 0x2004.
REQ-032 br_valid=1, Branch=1, ALUZero=1, br_pc=0x3000, br_imm=0x10, ack=1 -> redirect=1, instr_valid=0, next PC=0x3040; same stimulus with ALUZero=0 -> PC+4.
REQ-033 Uncondbranch=1 with halt=1 in the same cycle -> HALTED, PC held, imem_req=0 thereafter; resetl pulse -> IDLE.
REQ-034 br_pc=0xFFFFFFFFFFFFFFF0, br_imm=0x8, Uncondbranch=1 -> PC=0x10 (wrap).
REQ-035 With PC_ALIGN_CHECK_EN: target 0x3042 -> fault=1, imem_req=0, PC=0x3042; without the macro -> fetch continues at 0x3042.
